fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Small instruction FIFO between instruction fetch and the decode stage.
- Buffers fetched instruction/PC pairs and decouples fetch stalls from decode stalls.
- Presents the head entry to decode, with opcode and funct3 pre-sliced for the main decoder.
- Supports a full flush on redirect: taken branch, jal or jalr.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- XLEN, 64, PC width.
- ILEN, 32, instruction width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- f_valid_i  input  1  fetch presents an instruction.
- f_ready_o  output  1  queue can accept; equals !full.
- f_instr_i  input  ILEN  fetched instruction word.
- f_pc_i  input  XLEN  PC of the fetched instruction.
- d_valid_o  output  1  head entry valid for decode.
- d_ready_i  input  1  decode consumes the head this cycle.
- d_instr_o  output  ILEN  head instruction.
- d_pc_o  output  XLEN  head PC.
- d_opcode_o  output  7  d_instr_o[6:0].
- d_funct3_o  output  3  d_instr_o[14:12].
- flush_i  input  1  discard all entries; asserted on redirect.
- count_o  output  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - rd_ptr, wr_ptr and count are 0; d_valid_o=0; f_ready_o=1.
  - d_instr_o = NOP 32'h00000013; d_pc_o=0.
  - Storage contents are not reset.
- Push: when f_valid_i && f_ready_o, write {f_instr_i, f_pc_i} at wr_ptr, then increment wr_ptr.
- Pop: when d_valid_o && d_ready_i, increment rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count_o: +1 on push only, -1 on pop only, unchanged when both push and pop occur.
- f_ready_o = (count != DEPTH). It never depends combinationally on d_ready_i, so a full queue rejects a push even while popping.
- d_valid_o = (count != 0).
- d_instr_o/d_pc_o are read from storage at rd_ptr. When empty, d_instr_o = NOP and d_pc_o = 0.
- Latency: an entry pushed in cycle N is visible on d_valid_o in cycle N+1; there is no fall-through (except under the optional feature).
- Ordering: strictly FIFO; no reordering or duplication.
- Flush: flush_i=1 at a clock edge sets rd_ptr=wr_ptr=count=0.
  - Flush wins over push and pop in the same cycle; the same-cycle push is dropped.
  - d_valid_o is 0 from the next cycle.
  - While flush_i=1, d_valid_o is forced to 0 combinationally, so decode never consumes a killed entry.
- Full + push with no pop: push refused, state held.
- Empty + d_ready_i: no effect.
- Reset mid-stream: all entries discarded immediately; no partial state survives.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, f_valid_i=1 and flush_i=0, d_valid_o=1 in the same cycle with d_instr_o=f_instr_i and d_pc_o=f_pc_i.
  - If d_ready_i is also 1, the entry is consumed and not written (wr_ptr, count unchanged).
  - Otherwise it is written normally.
- Undefined: one-cycle minimum latency as above; no combinational path from fetch inputs to decode outputs.

Decomposition:
- Package fetch_pkg holds:
  - ILEN and XLEN defaults.
  - NOP_INSTR = 32'h00000013.
  - Shared RV64 opcode constants (load, store, op, op-imm, op-32, op-imm-32, branch, lui, auipc, jal, jalr), shared with the decoder.
  - Packed typedef fq_entry_t {instr, pc}.
- No sub-module: storage array, pointers and count stay inline in fetch_queue.

Test Plan:
- Reset, then push 4 entries (instr 32'h00A00093..32'h00D00093, pc 0x1000..0x100C) with d_ready_i=0 -> count_o=4, f_ready_o=0; a 5th push is refused.
- From full, hold d_ready_i=1 for 4 cycles -> pc 0x1000, 0x1004, 0x1008, 0x100C emerge in order; d_opcode_o=7'b0010011, d_funct3_o=3'b000; then d_valid_o=0 and d_instr_o=32'h00000013.
- Push and pop in the same cycle at count=2 -> count stays 2; head advances; 10 consecutive push/pop cycles wrap the pointers with correct order.
- At count=3, assert flush_i together with f_valid_i (pc 0x2000) -> next cycle count_o=0, d_valid_o=0; the 0x2000 push is dropped.
- Assert rst_n=0 asynchronously mid-cycle at count=2 -> d_valid_o=0 and count_o=0 immediately, before the next clock edge.
- Bypass (macro defined), empty queue, f_valid_i=1 (pc 0x3000), d_ready_i=1 -> d_valid_o=1 and d_pc_o=0x3000 the same cycle; count_o stays 0. Without the macro, d_valid_o rises one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared fetch/decode types and RV64 opcode constants
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int ILEN_DEF = 32;
    localparam int XLEN_DEF = 64;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
    localparam logic [6:0] OPC_STORE     = 7'b010_0011;
    localparam logic [6:0] OPC_OP        = 7'b011_0011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OPC_OP_32     = 7'b011_1011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
    localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
    localparam logic [6:0] OPC_LUI       = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
    localparam logic [6:0] OPC_JAL       = 7'b110_1111;
    localparam logic [6:0] OPC_JALR      = 7'b110_0111;

    typedef struct packed {
        logic [ILEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } fq_entry_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction/PC FIFO between fetch and decode, flushable.
//               Optional same-cycle bypass when empty: FETCH_QUEUE_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF,
    parameter int ILEN  = ILEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       f_valid_i,
    output logic                       f_ready_o,
    input  logic [ILEN-1:0]            f_instr_i,
    input  logic [XLEN-1:0]            f_pc_i,
    output logic                       d_valid_o,
    input  logic                       d_ready_i,
    output logic [ILEN-1:0]            d_instr_o,
    output logic [XLEN-1:0]            d_pc_o,
    output logic [6:0]                 d_opcode_o,
    output logic [2:0]                 d_funct3_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_push;
    logic w_pop;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_byp = w_empty && f_valid_i && !flush_i;
`else
    assign w_byp = 1'b0;
`endif

    assign f_ready_o = !w_full;
    // Flush masks valid so decode can never take an entry being killed.
    assign d_valid_o = !flush_i && (!w_empty || w_byp);

    always_comb begin
        d_instr_o = ILEN'(NOP_INSTR);
        d_pc_o    = '0;
        if (w_byp) begin
            d_instr_o = f_instr_i;
            d_pc_o    = f_pc_i;
        end else if (!w_empty) begin
            d_instr_o = instr_mem_q[rd_ptr_q];
            d_pc_o    = pc_mem_q[rd_ptr_q];
        end
    end

    assign d_opcode_o = d_instr_o[6:0];
    assign d_funct3_o = d_instr_o[14:12];
    assign count_o    = count_q;

    // A bypassed entry that decode takes immediately never lands in storage.
    assign w_push = f_valid_i && f_ready_o && !flush_i && !(w_byp && d_ready_i);
    assign w_pop  = d_valid_o && d_ready_i && !w_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            instr_mem_q[wr_ptr_q] <= f_instr_i;
            pc_mem_q[wr_ptr_q]    <= f_pc_i;
        end
    end

endmodule : fetch_queue

`default_nettype wire
